// File: rtl/mem_stage_ctrl_if.sv
// Bus bundle between the MEM-stage controller and its environment:
// the EX/MEM pipeline request, the data-memory port and the stall status.
interface mem_stage_ctrl_if;
    // Pipeline side (EX/MEM register contents)
    logic        mem_read_in;
    logic        mem_write_in;
    logic        is_ldi_in;
    logic        is_sti_in;
    logic [1:0]  mem_byte_enable_in;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;

    // Data-memory side
    logic        dmem_resp;
    logic [15:0] dmem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_enable;

    // Results back to the pipeline
    logic [15:0] mem_rdata_out;
    logic        stall_pipeline;
    logic [15:0] stall_count;

    // Controller view
    modport slave (
        input  mem_read_in, mem_write_in, is_ldi_in, is_sti_in,
               mem_byte_enable_in, addr_in, wdata_in, dmem_resp, dmem_rdata,
        output dmem_read, dmem_write, dmem_address, dmem_wdata,
               dmem_byte_enable, mem_rdata_out, stall_pipeline, stall_count
    );

    // Environment view (pipeline plus data memory)
    modport master (
        output mem_read_in, mem_write_in, is_ldi_in, is_sti_in,
               mem_byte_enable_in, addr_in, wdata_in, dmem_resp, dmem_rdata,
        input  dmem_read, dmem_write, dmem_address, dmem_wdata,
               dmem_byte_enable, mem_rdata_out, stall_pipeline, stall_count
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// LC-3b MEM-stage controller: issues direct loads/stores to data memory,
// sequences LDI/STI as a pointer fetch followed by the final access, and
// freezes the pipeline until the final access completes.
module mem_stage_ctrl (
    input  logic           clk,
    input  logic           reset,
    mem_stage_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PTR    = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] ptr_reg;
    logic [15:0] stall_cnt;
    logic        ptr_load;
    logic        final_resp;
    logic        op;
    logic        indirect;

    assign op       = bus.mem_read_in | bus.mem_write_in;
    assign indirect = (bus.is_ldi_in & bus.mem_read_in) | (bus.is_sti_in & bus.mem_write_in);

    assign bus.mem_rdata_out = bus.dmem_rdata;
    assign bus.stall_count   = stall_cnt;

    // Next-state, memory request and stall decode.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next           = state;
        ptr_load             = 1'b0;
        final_resp           = 1'b0;
        bus.dmem_read        = 1'b0;
        bus.dmem_write       = 1'b0;
        bus.dmem_address     = 16'h0000;
        bus.dmem_wdata       = 16'h0000;
        bus.dmem_byte_enable = 2'b00;

        case (state)
            IDLE: begin
                if (op) begin
                    if (indirect) begin
                        // Pointer fetch: always an aligned word read.
                        bus.dmem_read        = 1'b1;
                        bus.dmem_address     = {bus.addr_in[15:1], 1'b0};
                        bus.dmem_byte_enable = 2'b11;
                        if (bus.dmem_resp) begin
                            ptr_load   = 1'b1;
                            state_next = SECOND;
                        end else begin
                            state_next = PTR;
                        end
                    end else begin
                        // Read+write together is treated as a write.
                        bus.dmem_read        = bus.mem_read_in & ~bus.mem_write_in;
                        bus.dmem_write       = bus.mem_write_in;
                        bus.dmem_address     = bus.addr_in;
                        bus.dmem_wdata       = bus.wdata_in;
                        bus.dmem_byte_enable = bus.mem_byte_enable_in;
                        final_resp           = bus.dmem_resp;
                    end
                end
            end

            PTR: begin
                bus.dmem_read        = 1'b1;
                bus.dmem_address     = {bus.addr_in[15:1], 1'b0};
                bus.dmem_byte_enable = 2'b11;
                if (bus.dmem_resp) begin
                    ptr_load   = 1'b1;
                    state_next = SECOND;
                end
            end

            SECOND: begin
                bus.dmem_address     = {ptr_reg[15:1], 1'b0};
                bus.dmem_byte_enable = 2'b11;
                if (bus.mem_write_in) begin
                    bus.dmem_write = 1'b1;
                    bus.dmem_wdata = bus.wdata_in;
                end else begin
                    bus.dmem_read = 1'b1;
                end
                final_resp = bus.dmem_resp;
                if (bus.dmem_resp) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase

        bus.stall_pipeline = op & ~final_resp;
    end

    // State, pointer register and saturating stall counter.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state     <= IDLE;
            ptr_reg   <= 16'h0000;
            stall_cnt <= 16'h0000;
        end else begin
            state <= state_next;
            if (ptr_load) begin
                ptr_reg <= bus.dmem_rdata;
            end
            if (bus.stall_pipeline && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port mem_read_in, input, 1 bit: EX/MEM stage holds a load (LDR, LDB, LDI).
REQ-004 SHALL have port mem_write_in, input, 1 bit: EX/MEM stage holds a store (STR, STB, STI).
REQ-005 SHALL have ports is_ldi_in and is_sti_in, input, 1 bit each: indirect-op flags.
REQ-006 SHALL have port mem_byte_enable_in, input, 2 bits: byte lanes for a direct access.
REQ-007 SHALL have port addr_in, input, lc3b_word: effective address.
REQ-008 SHALL have port wdata_in, input, lc3b_word: store data.
REQ-009 SHALL have ports dmem_resp (1 bit) and dmem_rdata (lc3b_word), inputs: data-memory completion and read data.
REQ-010 SHALL have outputs dmem_read and dmem_write (1 bit each), dmem_address and dmem_wdata (lc3b_word each), and dmem_byte_enable (2 bits): data-memory request.
REQ-011 SHALL have output mem_rdata_out, lc3b_word: load data forwarded to MEM/WB.
REQ-012 SHALL have output stall_pipeline, 1 bit: freezes all pipeline registers.
REQ-013 SHALL have output stall_count, 16 bits: saturating count of stalled cycles.

Function
REQ-014 SHALL implement the FSM states IDLE, PTR (pointer fetch) and SECOND (indirect final access).
REQ-015 SHALL define op = mem_read_in | mem_write_in, and indirect = (is_ldi_in & mem_read_in) | (is_sti_in & mem_write_in).
REQ-016 SHALL, in IDLE with op and not indirect, drive dmem_read = mem_read_in & ~mem_write_in, dmem_write = mem_write_in, dmem_address = addr_in, dmem_wdata = wdata_in and dmem_byte_enable = mem_byte_enable_in.
REQ-017 SHALL, in IDLE with indirect, drive dmem_read=1, dmem_write=0, dmem_address = {addr_in[15:1],1'b0} and dmem_byte_enable=2'b11; this is the PTR access.
REQ-018 SHALL enter PTR from IDLE when indirect and dmem_resp=0, and remain in PTR driving the same request until dmem_resp=1.
REQ-019 SHALL, on dmem_resp=1 during a pointer access (in IDLE or PTR), latch ptr_reg = dmem_rdata and move to SECOND on the next edge.
REQ-020 SHALL, in SECOND, drive dmem_address = {ptr_reg[15:1],1'b0}, dmem_byte_enable=2'b11, dmem_read=1 for LDI or dmem_write=1 with dmem_wdata = wdata_in for STI, and return to IDLE on dmem_resp=1.
REQ-021 SHALL drive stall_pipeline = op & ~final_resp, where final_resp = dmem_resp in a direct IDLE access or in SECOND; a pointer-access response SHALL NOT clear stall.
REQ-022 SHALL drive mem_rdata_out = dmem_rdata combinationally in every cycle.
REQ-023 SHALL, in IDLE with op=0, drive dmem_read=0, dmem_write=0, dmem_address=0, dmem_wdata=0, dmem_byte_enable=2'b00 and stall_pipeline=0.
REQ-024 SHALL ignore dmem_resp in IDLE when op=0.
REQ-025 SHALL accept a dmem_resp in the same cycle as the request (zero-wait memory); a direct op then completes in 1 cycle with no stall, and an indirect op in 2 cycles with 1 stall cycle.
REQ-026 SHALL treat mem_read_in=mem_write_in=1 as a write.
REQ-027 SHALL increment stall_count on each edge where stall_pipeline=1, saturating at 16'hFFFF.

Reset
REQ-028 SHALL, on reset assertion (including mid-access in PTR or SECOND), immediately force the state to IDLE, ptr_reg to 16'h0000 and stall_count to 16'h0000; outputs then follow REQ-016/017/023 for the current inputs.
REQ-029 SHALL, after reset release, treat a still-present op as a new access starting from IDLE.

Verification
REQ-030 SHALL cover: LDR with addr_in=16'h1234 and dmem_resp after 3 cycles -> dmem_read for 3 cycles, stall_pipeline=1 for 2 cycles, stall_count=2.
REQ-031 SHALL cover: LDI with addr_in=16'h3001, pointer response 16'h4002, then data 16'hBEEF -> PTR address 16'h3000, SECOND read at 16'h4002, mem_rdata_out=16'hBEEF in the final cycle, stall released in that cycle.
REQ-032 SHALL cover: STI with addr_in=16'h2000, pointer 16'h5000 and wdata_in=16'hA5A5 -> write at 16'h5000 with byte_enable 2'b11, and no write asserted during the pointer access.
REQ-033 SHALL cover: STB with mem_byte_enable_in=2'b10 and zero-wait response -> single-cycle write with byte_enable 2'b10 and stall_pipeline=0.
REQ-034 SHALL cover: reset asserted in SECOND -> state IDLE, stall_count=0, and no dmem_write in the cycle after reset release unless an op is present.
REQ-035 SHALL cover: stall_count preloaded near saturation with continued stalling -> the count holds at 16'hFFFF.
